// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one FU result per cycle onto the registered common data bus.
// ack is combinational; the broadcast appears one cycle later. No grants while cdb_ready is low or during squash.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int FU_IDX_W  = $clog2(NUM_FU),
    parameter int CNT_W     = 32,
    parameter int XLEN      = 32,
    parameter int ROB_TAG_W = 5,
    parameter int PKT_W     = 3 * XLEN + ROB_TAG_W + 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    squash,
    input  logic                    cdb_ready,
    input  logic [NUM_FU*PKT_W-1:0] fu_out_packet,
    output logic [NUM_FU-1:0]       ack,
    output logic                    cdb_valid,
    output logic [ROB_TAG_W-1:0]    cdb_rob_tag,
    output logic [XLEN-1:0]         cdb_value,
    output logic                    cdb_take_branch,
    output logic [XLEN-1:0]         cdb_branch_loc,
    output logic                    cdb_mispredicted,
    output logic [XLEN-1:0]         cdb_origin_PC,
    output logic [FU_IDX_W-1:0]     cdb_src_fu,
    output logic [CNT_W-1:0]        cdb_count
);

    // Packet layout, MSB first: done, rob_tag, v, take_branch, branch_loc, mispredicted, origin_PC.
    localparam int MP_B = XLEN;
    localparam int BL_L = XLEN + 1;
    localparam int TB_B = 2 * XLEN + 1;
    localparam int V_L  = 2 * XLEN + 2;
    localparam int TG_L = 3 * XLEN + 2;

    logic [FU_IDX_W-1:0] rr_ptr;
    logic [NUM_FU-1:0]   req;
    logic [NUM_FU-1:0]   gnt_onehot;
    logic [FU_IDX_W-1:0] gnt_idx;
    logic [FU_IDX_W-1:0] next_ptr;
    logic [PKT_W-2:0]    sel_pkt;
    logic                found;
    logic                grant_en;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            req[i] = fu_out_packet[i*PKT_W + PKT_W - 1];
        end
    end

    // First pass covers rr_ptr..NUM_FU-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        found      = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        sel_pkt    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (!found && req[i] && (FU_IDX_W'(i) >= rr_ptr)) begin
                found         = 1'b1;
                gnt_idx       = FU_IDX_W'(i);
                gnt_onehot[i] = 1'b1;
                sel_pkt       = fu_out_packet[i*PKT_W +: PKT_W-1];
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (!found && req[i]) begin
                found         = 1'b1;
                gnt_idx       = FU_IDX_W'(i);
                gnt_onehot[i] = 1'b1;
                sel_pkt       = fu_out_packet[i*PKT_W +: PKT_W-1];
            end
        end
    end

    assign grant_en = reset & cdb_ready & ~squash & found;
    assign ack      = grant_en ? gnt_onehot : '0;
    assign next_ptr = (gnt_idx == FU_IDX_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr           <= '0;
            cdb_valid        <= 1'b0;
            cdb_rob_tag      <= '0;
            cdb_value        <= '0;
            cdb_take_branch  <= 1'b0;
            cdb_branch_loc   <= '0;
            cdb_mispredicted <= 1'b0;
            cdb_origin_PC    <= '0;
            cdb_src_fu       <= '0;
            cdb_count        <= '0;
        end else if (grant_en) begin
            rr_ptr           <= next_ptr;
            cdb_valid        <= 1'b1;
            cdb_rob_tag      <= sel_pkt[TG_L +: ROB_TAG_W];
            cdb_value        <= sel_pkt[V_L +: XLEN];
            cdb_take_branch  <= sel_pkt[TB_B];
            cdb_branch_loc   <= sel_pkt[BL_L +: XLEN];
            cdb_mispredicted <= sel_pkt[MP_B];
            cdb_origin_PC    <= sel_pkt[XLEN-1:0];
            cdb_src_fu       <= gnt_idx;
            cdb_count        <= cdb_count + 1'b1;
        end else begin
            // Single-entry broadcast: nothing granted means nothing on the bus.
            if (squash) begin
                rr_ptr <= '0;
            end
            cdb_valid        <= 1'b0;
            cdb_rob_tag      <= '0;
            cdb_value        <= '0;
            cdb_take_branch  <= 1'b0;
            cdb_branch_loc   <= '0;
            cdb_mispredicted <= 1'b0;
            cdb_origin_PC    <= '0;
            cdb_src_fu       <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors plus hand sequences for reset corners.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int PKT_W  = 3 * 32 + 5 + 3;

    logic                    clk;
    logic                    rst_n;
    logic                    squash;
    logic                    cdb_ready;
    logic [PKT_W-1:0]        pk [NUM_FU];
    logic [NUM_FU*PKT_W-1:0] fu_out_packet;
    logic [NUM_FU-1:0]       ack;
    logic                    cdb_valid;
    logic [4:0]              cdb_rob_tag;
    logic [31:0]             cdb_value;
    logic                    cdb_take_branch;
    logic [31:0]             cdb_branch_loc;
    logic                    cdb_mispredicted;
    logic [31:0]             cdb_origin_PC;
    logic [1:0]              cdb_src_fu;
    logic [31:0]             cdb_count;

    int checks = 0;
    int errors = 0;

    assign fu_out_packet = {pk[3], pk[2], pk[1], pk[0]};

    cdb_arbiter dut (
        .clock            (clk),
        .reset            (rst_n),
        .squash           (squash),
        .cdb_ready        (cdb_ready),
        .fu_out_packet    (fu_out_packet),
        .ack              (ack),
        .cdb_valid        (cdb_valid),
        .cdb_rob_tag      (cdb_rob_tag),
        .cdb_value        (cdb_value),
        .cdb_take_branch  (cdb_take_branch),
        .cdb_branch_loc   (cdb_branch_loc),
        .cdb_mispredicted (cdb_mispredicted),
        .cdb_origin_PC    (cdb_origin_PC),
        .cdb_src_fu       (cdb_src_fu),
        .cdb_count        (cdb_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  done;
        logic        rdy;
        logic        sq;
        logic [3:0]  exp_ack;
        logic        exp_vld;
        logic [1:0]  exp_src;
        logic [31:0] exp_cnt;
        logic [1:0]  exp_rr;
    } vec_t;

    vec_t tbl [22];

    function automatic logic [PKT_W-1:0] mkpkt(input logic d, input int i);
        logic [31:0] iv;
        iv = i;
        return {d, 5'(10 + i), 32'hC0DE_0000 + iv, iv[0], 32'h0000_B000 + iv, iv[1], 32'h0000_4000 + 4 * iv};
    endfunction

    task automatic drive(input logic [3:0] done, input logic rdy, input logic sq);
        for (int i = 0; i < NUM_FU; i++) pk[i] = mkpkt(done[i], i);
        cdb_ready = rdy;
        squash    = sq;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_cdb(input string nm, input logic vld, input logic [1:0] src,
                           input logic [31:0] cnt, input logic [1:0] rr);
        logic [31:0] s;
        s = {30'd0, src};
        chk({nm, ".valid"}, cdb_valid, vld);
        chk({nm, ".tag"},   cdb_rob_tag, vld ? 5'(10 + s) : 5'd0);
        chk({nm, ".value"}, cdb_value, vld ? 32'hC0DE_0000 + s : 32'd0);
        chk({nm, ".tb"},    cdb_take_branch, vld & src[0]);
        chk({nm, ".bloc"},  cdb_branch_loc, vld ? 32'h0000_B000 + s : 32'd0);
        chk({nm, ".mp"},    cdb_mispredicted, vld & src[1]);
        chk({nm, ".pc"},    cdb_origin_PC, vld ? 32'h0000_4000 + 4 * s : 32'd0);
        chk({nm, ".src"},   cdb_src_fu, vld ? src : 2'd0);
        chk({nm, ".count"}, cdb_count, cnt);
        chk({nm, ".rr"},    dut.rr_ptr, rr);
    endtask

    initial begin
        // done, rdy, sq, ack, observed vld/src/count/rr
        tbl[0]  = '{4'b1010, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd0, 32'd1,  2'd3};
        tbl[1]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd3, 32'd2,  2'd0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd3,  2'd2};
        tbl[3]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd3,  2'd2};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 32'd3,  2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 32'd4,  2'd1};
        tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 32'd5,  2'd2};
        tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 32'd6,  2'd3};
        tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 32'd7,  2'd0};
        tbl[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 32'd8,  2'd1};
        tbl[10] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 32'd9,  2'd2};
        tbl[11] = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 32'd10, 2'd3};
        tbl[12] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 32'd11, 2'd0};
        tbl[13] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd11, 2'd0};
        tbl[14] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd11, 2'd0};
        tbl[15] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd11, 2'd0};
        tbl[16] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 32'd11, 2'd0};
        tbl[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd12, 2'd2};
        tbl[18] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 32'd12, 2'd2};
        tbl[19] = '{4'b0010, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 32'd13, 2'd1};
        tbl[20] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd13, 2'd0};
        tbl[21] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 32'd13, 2'd0};

        // Reset held with requests pending: no ack, all outputs clear.
        rst_n = 1'b0;
        drive(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk("reset.ack", ack, 4'b0000);
        chk_cdb("reset", 1'b0, 2'd0, 32'd0, 2'd0);

        // First grant: fu2 with rob_tag 5, v 0x1234.
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(4'b0000, 1'b1, 1'b0);
        pk[2] = {1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 32'd0};
        @(negedge clk);
        chk("first.ack", ack, 4'b0100);
        @(posedge clk); #1;
        drive(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        chk("first.valid", cdb_valid, 1'b1);
        chk("first.tag", cdb_rob_tag, 5'd5);
        chk("first.value", cdb_value, 32'h0000_1234);
        chk("first.src", cdb_src_fu, 2'd2);
        chk("first.rr", dut.rr_ptr, 2'd3);
        chk("first.count", cdb_count, 32'd1);

        for (int r = 0; r < 22; r++) begin
            @(posedge clk); #1;
            drive(tbl[r].done, tbl[r].rdy, tbl[r].sq);
            @(negedge clk);
            chk($sformatf("row%0d.ack", r), ack, tbl[r].exp_ack);
            chk_cdb($sformatf("row%0d", r), tbl[r].exp_vld, tbl[r].exp_src, tbl[r].exp_cnt, tbl[r].exp_rr);
        end

        // Reset mid-broadcast clears everything without a clock edge.
        @(posedge clk); #1;
        drive(4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid.ack", ack, 4'b0001);
        @(posedge clk); #1;
        drive(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk_cdb("mid.pre", 1'b1, 2'd0, 32'd14, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cdb("mid.rst", 1'b0, 2'd0, 32'd0, 2'd0);
        chk("mid.rst.ack", ack, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        chk_cdb("post", 1'b0, 2'd0, 32'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
